// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline memory stage.
//   DW          datapath / memory data and address width
//   RW          register-number width
//   mem_state_t data-memory handshake FSM states
package pipe_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack handshake FSM with stall generation.
//   clock, reset  rising-edge clock, async active-high reset
//   mem_op_i      M-stage instruction is a load or a store
//   we_i          M-stage instruction is a store
//   ack_i         memory access completes this cycle
//   req_c         memory request valid (combinational)
//   stall_c       hold the upstream stages (combinational)
//   rd_ack_c      read data is valid this cycle (combinational)
module dmem_handshake
  import pipe_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic mem_op_i,
  input  logic we_i,
  input  logic ack_i,
  output logic req_c,
  output logic stall_c,
  output logic rd_ack_c
);

  mem_state_t state_q, state_d;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= M_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request/stall decode; an ack without a request is ignored
  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    rd_ack_c = 1'b0;
    case (state_q)
      M_IDLE: begin
        req_c = mem_op_i;
        if (mem_op_i && !ack_i) begin
          state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        req_c = 1'b1;
        if (ack_i) begin
          state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
    stall_c  = req_c & ~ack_i;
    rd_ack_c = req_c & ack_i & ~we_i;
  end

endmodule

// File: rtl/pipemem_stage.sv
// EXE/MEM register, data-memory access and MEM/WB register.
//   clock, reset        rising-edge clock, async active-high reset
//   ealu/ebs/ern        EXE result, store data, destination
//   ewreg/em2reg/ewmem  EXE control: reg write, load, store
//   mstall              hold upstream stages and the EXE/MEM register
//   malu/mrn/mwreg/mm2reg  M-stage values (forwarding / hazard sources)
//   dmem_*              data-memory request/ack interface
//   wmo/walu/wrn/wwreg/wm2reg  W-stage values for write-back
module pipemem_stage #(
  parameter int unsigned DW = pipe_pkg::DW,
  parameter int unsigned RW = pipe_pkg::RW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] ealu,
  input  logic [DW-1:0] ebs,
  input  logic [RW-1:0] ern,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic          ewmem,
  output logic          mstall,
  output logic [DW-1:0] malu,
  output logic [RW-1:0] mrn,
  output logic          mwreg,
  output logic          mm2reg,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [DW-1:0] wmo,
  output logic [DW-1:0] walu,
  output logic [RW-1:0] wrn,
  output logic          wwreg,
  output logic          wm2reg
);

  logic [DW-1:0] malu_q, mbs_q;
  logic [RW-1:0] mrn_q;
  logic          mwreg_q, mm2reg_q, mwmem_q;
  logic [DW-1:0] wmo_q, walu_q;
  logic [RW-1:0] wrn_q;
  logic          wwreg_q, wm2reg_q;
  logic          req_c, stall_c, rd_ack_c;

  dmem_handshake u_hs (
    .clock    (clock),
    .reset    (reset),
    .mem_op_i (mm2reg_q | mwmem_q),
    .we_i     (mwmem_q),
    .ack_i    (dmem_ack),
    .req_c    (req_c),
    .stall_c  (stall_c),
    .rd_ack_c (rd_ack_c)
  );

  // EXE/MEM register: holds during a stall so address/data stay stable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      malu_q   <= '0;
      mbs_q    <= '0;
      mrn_q    <= '0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
    end else if (!stall_c) begin
      malu_q   <= ealu;
      mbs_q    <= ebs;
      mrn_q    <= ern;
      mwreg_q  <= ewreg;
      mm2reg_q <= em2reg;
      mwmem_q  <= ewmem;
    end
  end

  // MEM/WB register: a stall cycle sends a bubble; wmo only moves on a read ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
    end else begin
      if (rd_ack_c) begin
        wmo_q <= dmem_rdata;
      end
      if (stall_c) begin
        wwreg_q  <= 1'b0;
        wm2reg_q <= 1'b0;
      end else begin
        walu_q   <= malu_q;
        wrn_q    <= mrn_q;
        wwreg_q  <= mwreg_q;
        wm2reg_q <= mm2reg_q;
      end
    end
  end

  assign mstall     = stall_c;
  assign malu       = malu_q;
  assign mrn        = mrn_q;
  assign mwreg      = mwreg_q;
  assign mm2reg     = mm2reg_q;
  assign dmem_req   = req_c;
  assign dmem_we    = mwmem_q;
  // Word access only: low address bits are dropped
  assign dmem_addr  = {malu_q[DW-1:2], 2'b00};
  assign dmem_wdata = mbs_q;
  assign wmo        = wmo_q;
  assign walu       = walu_q;
  assign wrn        = wrn_q;
  assign wwreg      = wwreg_q;
  assign wm2reg     = wm2reg_q;

endmodule

// File: tb/tb_pipemem_stage.sv
module tb_pipemem_stage;
  import pipe_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   ealu, ebs, dmem_rdata;
  logic [4:0]    ern;
  logic          ewreg, em2reg, ewmem, dmem_ack;
  logic          mstall, mwreg, mm2reg, dmem_req, dmem_we, wwreg, wm2reg;
  logic [31:0]   malu, dmem_addr, dmem_wdata, wmo, walu;
  logic [4:0]    mrn, wrn;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipemem_stage u_dut (
    .clock      (clock),
    .reset      (reset),
    .ealu       (ealu),
    .ebs        (ebs),
    .ern        (ern),
    .ewreg      (ewreg),
    .em2reg     (em2reg),
    .ewmem      (ewmem),
    .mstall     (mstall),
    .malu       (malu),
    .mrn        (mrn),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .wmo        (wmo),
    .walu       (walu),
    .wrn        (wrn),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic exe(input logic [31:0] alu, input logic [31:0] bs, input logic [4:0] rn,
                     input logic wr, input logic ld, input logic st);
    ealu = alu; ebs = bs; ern = rn; ewreg = wr; em2reg = ld; ewmem = st;
  endtask

  initial begin
    reset = 1'b1;
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    #12;
    chk("rst_malu", malu, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, mstall}, 32'h0);
    chk("rst_wmo", wmo, 32'h0);
    chk("rst_wwreg", {31'h0, wwreg}, 32'h0);
    reset = 1'b0;

    // ALU op through both registers
    exe(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("alu_malu", malu, 32'h10);
    chk("alu_mrn", {27'h0, mrn}, 32'd5);
    chk("alu_mwreg", {31'h0, mwreg}, 32'h1);
    chk("alu_stall", {31'h0, mstall}, 32'h0);
    chk("alu_req", {31'h0, dmem_req}, 32'h0);
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("alu_walu", walu, 32'h10);
    chk("alu_wrn", {27'h0, wrn}, 32'd5);
    chk("alu_wwreg", {31'h0, wwreg}, 32'h1);

    // Load acked in the same cycle
    exe(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld0_stall", {31'h0, mstall}, 32'h0);
    chk("ld0_req", {31'h0, dmem_req}, 32'h1);
    chk("ld0_we", {31'h0, dmem_we}, 32'h0);
    chk("ld0_addr", dmem_addr, 32'h40);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("ld0_wmo", wmo, 32'hDEADBEEF);
    chk("ld0_wm2reg", {31'h0, wm2reg}, 32'h1);
    chk("ld0_wrn", {27'h0, wrn}, 32'd7);
    chk("ld0_req_after", {31'h0, dmem_req}, 32'h0);

    // Store with three wait cycles; an ALU op waits in EXE behind it
    exe(32'h24, 32'hA5, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    exe(32'h77, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", {31'h0, mstall}, 32'h1);
      chk("st_req", {31'h0, dmem_req}, 32'h1);
      chk("st_we", {31'h0, dmem_we}, 32'h1);
      chk("st_addr", dmem_addr, 32'h24);
      chk("st_wdata", dmem_wdata, 32'hA5);
      chk("st_malu", malu, 32'h24);
      tick();
      chk("st_bubble", {31'h0, wwreg}, 32'h0);
    end
    dmem_ack = 1'b1;
    #1;
    chk("st_ack_stall", {31'h0, mstall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("st_next_malu", malu, 32'h77);
    chk("st_next_mrn", {27'h0, mrn}, 32'd3);
    chk("st_w_wwreg", {31'h0, wwreg}, 32'h0);
    chk("st_wmo_hold", wmo, 32'hDEADBEEF);
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("st_alu_walu", walu, 32'h77);
    chk("st_alu_wwreg", {31'h0, wwreg}, 32'h1);

    // Load with two wait cycles followed by an ALU op (misaligned address)
    exe(32'h83, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    exe(32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("ld2_addr", dmem_addr, 32'h80);
    for (int i = 0; i < 2; i++) begin
      chk("ld2_stall", {31'h0, mstall}, 32'h1);
      chk("ld2_malu", malu, 32'h83);
      chk("ld2_mrn", {27'h0, mrn}, 32'd9);
      tick();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("ld2_ack_stall", {31'h0, mstall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("ld2_next_malu", malu, 32'h55);
    chk("ld2_wmo", wmo, 32'hCAFEF00D);
    chk("ld2_wm2reg", {31'h0, wm2reg}, 32'h1);
    chk("ld2_wrn", {27'h0, wrn}, 32'd9);
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ld2_alu_walu", walu, 32'h55);
    chk("ld2_alu_wm2reg", {31'h0, wm2reg}, 32'h0);
    chk("ld2_wmo_hold", wmo, 32'hCAFEF00D);

    // Reset while waiting on a store
    exe(32'h100, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rw_req_pre", {31'h0, dmem_req}, 32'h1);
    chk("rw_state_pre", {31'h0, u_dut.u_hs.state_q}, {31'h0, M_WAIT});
    reset = 1'b1;
    #1;
    chk("rw_req", {31'h0, dmem_req}, 32'h0);
    chk("rw_stall", {31'h0, mstall}, 32'h0);
    chk("rw_malu", malu, 32'h0);
    chk("rw_wdata", dmem_wdata, 32'h0);
    chk("rw_walu", walu, 32'h0);
    chk("rw_wmo", wmo, 32'h0);
    #6;
    reset = 1'b0;
    tick();
    chk("rw_state_post", {31'h0, u_dut.u_hs.state_q}, {31'h0, M_IDLE});
    chk("rw_req_post", {31'h0, dmem_req}, 32'h0);

    // Spurious ack with only ALU ops in flight
    exe(32'h33, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("sp_req", {31'h0, dmem_req}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("sp_wmo", wmo, 32'h0);
    chk("sp_malu", malu, 32'h33);
    chk("sp_walu", walu, 32'h33);
    chk("sp_wm2reg", {31'h0, wm2reg}, 32'h0);
    chk("sp_stall", {31'h0, mstall}, 32'h0);
    chk("sp_state", {31'h0, u_dut.u_hs.state_q}, {31'h0, M_IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
